// File: rtl/instr_sequencer.sv
// Program sequencer: 32x9 program memory feeding instructions/immediates to a control unit.
// Build option INSTR_SEQ_WRAP_EN: pc wraps 31->0 instead of halting at the end of memory.
//
// state  | meaning
// IDLE   | waiting for start; program memory writable
// LOAD   | fetch mem[pc], decode HALT / reserved-NOP / executable
// ISSUE  | run=1 with din=mem[pc]; mvi moves on to IMM after one cycle
// IMM    | run=1 with din=mem[pc+1] (mvi immediate) until done
// HALTED | program ended; memory writable, start restarts at 0
module instr_sequencer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [8:0] wr_data,
  input  logic       done,
  output logic [8:0] din,
  output logic       run,
  output logic [4:0] pc,
  output logic       busy,
  output logic       halted
);
`ifdef INSTR_SEQ_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_IMM, S_HALTED} state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [8:0] mem_q [32];
  logic [4:0] pc_p1, pc_p2;
  logic [8:0] cur_w, imm_w;
  logic [2:0] op_w;
  logic       at_end_w;

  assign pc_p1    = pc_q + 5'd1;
  assign pc_p2    = pc_q + 5'd2;
  assign cur_w    = mem_q[pc_q];
  assign imm_w    = mem_q[pc_p1];
  assign op_w     = cur_w[8:6];
  assign at_end_w = (pc_q == 5'd31) && !WRAP;
  assign pc       = pc_q;

  // Memory is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE || state_q == S_HALTED))
      mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din     = 9'd0;
    run     = 1'b0;
    busy    = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        halted = (state_q == S_HALTED);
        if (start) begin
          pc_d    = 5'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        din  = cur_w;
        busy = 1'b1;
        if (op_w == 3'b111) begin
          state_d = S_HALTED;
        end else if (op_w[2]) begin
          if (at_end_w) state_d = S_HALTED;
          else          pc_d    = pc_p1;
        end else if (op_w == 3'b001 && at_end_w) begin
          // mvi with no immediate slot left: stop before asserting run
          state_d = S_HALTED;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        din  = cur_w;
        run  = 1'b1;
        busy = 1'b1;
        if (op_w == 3'b001) begin
          state_d = S_IMM;
        end else if (done) begin
          if (at_end_w) begin
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_p1;
            state_d = S_LOAD;
          end
        end
      end
      S_IMM: begin
        din  = imm_w;
        run  = 1'b1;
        busy = 1'b1;
        if (done) begin
          if (!WRAP && pc_q >= 5'd30) begin
            pc_d    = 5'd31;
            state_d = S_HALTED;
          end else begin
            pc_d    = pc_p2;
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
